// File: rtl/pal_timing_gen_if.sv
// Raster position and window flags produced by pal_timing_gen, plus its two control inputs.
// slave is the generator's view; master is the view of whoever drives en/phase_alt and consumes the raster.
interface pal_timing_gen_if #(
  parameter int SUB_W = 2,
  parameter int X_W   = 9,
  parameter int Y_W   = 10
);
  logic             en_i;
  logic             phase_alt_i;
  logic [SUB_W-1:0] subpixel_o;
  logic [X_W-1:0]   pixel_x_o;
  logic [Y_W-1:0]   line_y_o;
  logic             vswitch_o;
  logic             hsync_o;
  logic             vsync_o;
  logic             csync_o;
  logic             burst_o;
  logic             active_o;
  logic             carrier_o;
  logic             line_start_o;
  logic             frame_start_o;

  modport slave (
    input  en_i, phase_alt_i,
    output subpixel_o, pixel_x_o, line_y_o, vswitch_o,
           hsync_o, vsync_o, csync_o, burst_o, active_o,
           carrier_o, line_start_o, frame_start_o
  );

  modport master (
    output en_i, phase_alt_i,
    input  subpixel_o, pixel_x_o, line_y_o, vswitch_o,
           hsync_o, vsync_o, csync_o, burst_o, active_o,
           carrier_o, line_start_o, frame_start_o
  );
endinterface

// File: rtl/pal_timing_gen.sv
// Composite-video raster timing generator: subpixel/pixel/line cascade, sync/burst/active windows
// and line-alternating subcarrier bit, every output a flop so the whole set changes on one edge.
module pal_timing_gen #(
  parameter int SUB_W          = 2,
  parameter int X_W            = 9,
  parameter int Y_W            = 10,
  parameter int H_TOTAL        = 284,
  parameter int V_TOTAL        = 625,
  parameter int H_SYNC         = 21,
  parameter int H_BURST_START  = 25,
  parameter int H_BURST        = 10,
  parameter int H_ACTIVE_START = 46,
  parameter int H_ACTIVE       = 231,
  parameter int V_SYNC         = 5,
  parameter int V_ACTIVE_START = 23,
  parameter int V_ACTIVE       = 576
) (
  input logic             clk,
  input logic             rst_n,
  pal_timing_gen_if.slave vid
);

  localparam logic [X_W-1:0]   X_LAST  = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(V_TOTAL - 1);
  // Window bounds carry one extra bit so an end bound equal to 2^X_W / 2^Y_W still fits.
  localparam logic [X_W:0]     HS_END  = (X_W+1)'(H_SYNC);
  localparam logic [X_W:0]     HB_BEG  = (X_W+1)'(H_BURST_START);
  localparam logic [X_W:0]     HB_END  = (X_W+1)'(H_BURST_START + H_BURST);
  localparam logic [X_W:0]     HA_BEG  = (X_W+1)'(H_ACTIVE_START);
  localparam logic [X_W:0]     HA_END  = (X_W+1)'(H_ACTIVE_START + H_ACTIVE);
  localparam logic [Y_W:0]     VS_END  = (Y_W+1)'(V_SYNC);
  localparam logic [Y_W:0]     VA_BEG  = (Y_W+1)'(V_ACTIVE_START);
  localparam logic [Y_W:0]     VA_END  = (Y_W+1)'(V_ACTIVE_START + V_ACTIVE);
  // -90 degrees of subcarrier expressed in subpixels.
  localparam logic [SUB_W-1:0] CAR_OFF = SUB_W'((1 << SUB_W) - (1 << (SUB_W - 2)));

  logic [SUB_W-1:0] sub_q, sub_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             vsw_q, vsw_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             csync_q, csync_d;
  logic             burst_q, burst_d;
  logic             active_q, active_d;
  logic             carrier_q, carrier_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  logic             pix_adv;
  logic             line_adv;
  logic [X_W:0]     x_ext;
  logic [Y_W:0]     y_ext;
  logic [SUB_W-1:0] car_sum;

  // Flags are derived from the next counter state so they land on the same edge as the counters.
  always_comb begin
    pix_adv  = &sub_q;
    line_adv = pix_adv && (x_q == X_LAST);

    sub_d = sub_q + SUB_W'(1);

    x_d = x_q;
    if (pix_adv) begin
      x_d = (x_q == X_LAST) ? '0 : x_q + X_W'(1);
    end

    y_d = y_q;
    if (line_adv) begin
      y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
    end

    vsw_d = vsw_q ^ line_adv;

    x_ext = {1'b0, x_d};
    y_ext = {1'b0, y_d};

    hsync_d  = (x_ext < HS_END);
    vsync_d  = (y_ext < VS_END);
    csync_d  = hsync_d ^ vsync_d;
    burst_d  = (x_ext >= HB_BEG) && (x_ext < HB_END) && !vsync_d;
    active_d = (x_ext >= HA_BEG) && (x_ext < HA_END) &&
               (y_ext >= VA_BEG) && (y_ext < VA_END);

    car_sum   = sub_d + ((vid.phase_alt_i && vsw_d) ? CAR_OFF : '0);
    carrier_d = car_sum[SUB_W-1];

    line_start_d  = (sub_d == '0) && (x_d == '0);
    frame_start_d = line_start_d && (y_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      vsw_q         <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      csync_q       <= 1'b0;
      burst_q       <= 1'b0;
      active_q      <= 1'b0;
      carrier_q     <= 1'b0;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else if (vid.en_i) begin
      sub_q         <= sub_d;
      x_q           <= x_d;
      y_q           <= y_d;
      vsw_q         <= vsw_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      csync_q       <= csync_d;
      burst_q       <= burst_d;
      active_q      <= active_d;
      carrier_q     <= carrier_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.subpixel_o    = sub_q;
  assign vid.pixel_x_o     = x_q;
  assign vid.line_y_o      = y_q;
  assign vid.vswitch_o     = vsw_q;
  assign vid.hsync_o       = hsync_q;
  assign vid.vsync_o       = vsync_q;
  assign vid.csync_o       = csync_q;
  assign vid.burst_o       = burst_q;
  assign vid.active_o      = active_q;
  assign vid.carrier_o     = carrier_q;
  assign vid.line_start_o  = line_start_q;
  assign vid.frame_start_o = frame_start_q;

endmodule
